tm1638_responder: RTL and testbench

Synthesizable TM1638 device-side endpoint. It is the responder to tm1638_board_controller and receives STB/CLK/DIO from any TM1638 host.
- Decodes data, address and display-control commands.
- Holds the 16-byte display RAM and the display-control state.
- Shifts a 32-bit key-scan snapshot back to the host on read.
- Used in on-board loopback tests and simulation benches, and as a bridge from TM1638 hosts to other display hardware.

---
 rtl/tm1638_pkg.sv | 55 +++++
 rtl/tm1638_sio_sync_edge.sv | 25 ++
 rtl/tm1638_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared TM1638 protocol definitions: command codes, field masks, widths and FSM states.
// Used by both the responder and the board controller.
package tm1638_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned RAM_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RAM_W     = RAM_DEPTH * BYTE_W;
  localparam int unsigned KEY_W     = 32;
  localparam int unsigned RD_CNT_W  = 6;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [BYTE_W-1:0] C_READ_KEYS  = 8'h42;
  localparam logic [BYTE_W-1:0] C_WRITE_DISP = 8'h40;
  localparam logic [BYTE_W-1:0] C_SET_ADDR_0 = 8'hC0;
  localparam logic [BYTE_W-1:0] C_DISPLAY_ON = 8'h8F;

  // Command class lives in the top two bits; the rest are class-specific fields.
  localparam logic [BYTE_W-1:0] CMD_TYPE_MASK    = 8'hC0;
  localparam logic [BYTE_W-1:0] CMD_TYPE_DATA    = C_WRITE_DISP & CMD_TYPE_MASK;
  localparam logic [BYTE_W-1:0] CMD_TYPE_DISP    = C_DISPLAY_ON & CMD_TYPE_MASK;
  localparam logic [BYTE_W-1:0] CMD_TYPE_ADDR    = C_SET_ADDR_0 & CMD_TYPE_MASK;
  localparam logic [BYTE_W-1:0] DATA_READ_MASK   = C_READ_KEYS ^ C_WRITE_DISP;
  localparam logic [BYTE_W-1:0] DATA_FIXED_MASK  = 8'h04;
  localparam logic [BYTE_W-1:0] ADDR_MASK        = 8'h0F;
  localparam logic [BYTE_W-1:0] DISP_ON_MASK     = 8'h08;
  localparam logic [BYTE_W-1:0] DISP_BRIGHT_MASK = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_DISCARD
  } state_t;

  typedef enum logic [1:0] {
    K_ERROR,
    K_DATA,
    K_DISP,
    K_ADDR
  } cmd_kind_t;

  function automatic cmd_kind_t cmd_kind(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] t;
    cmd_kind_t k;
    t = b & CMD_TYPE_MASK;
    k = K_ERROR;
    if (t == CMD_TYPE_DATA) k = K_DATA;
    if (t == CMD_TYPE_DISP) k = K_DISP;
    if (t == CMD_TYPE_ADDR) k = K_ADDR;
    return k;
  endfunction

endpackage

// File: rtl/tm1638_sio_sync_edge.sv
// Pin synchronizer followed by a one-flop edge detector for one SIO input.
// Flops are left unreset so the chain keeps tracking the pin through rst and no false edge appears on release.
module tm1638_sio_sync_edge #(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [stages-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[stages-2:0], din};
    last_q <= sync_q[stages-1];
  end

  assign level  = sync_q[stages-1];
  assign rise_c = sync_q[stages-1] & ~last_q;
  assign fall_c = ~sync_q[stages-1] & last_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side endpoint: decodes host commands, holds display RAM and
// display control, and returns a key-scan snapshot on read.
module tm1638_responder
  import tm1638_pkg::*;
#(
  parameter int unsigned clk_mhz     = 50,
  parameter int unsigned sync_stages = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sio_clk,
  input  logic               sio_stb,
  input  logic               sio_data_in,
  output logic               sio_data_out,
  output logic               sio_data_out_en,
  input  logic [KEY_W-1:0]   key_matrix,
  output logic [RAM_W-1:0]   disp_ram,
  output logic               display_on,
  output logic [2:0]         brightness,
  output logic               frame_done,
  output logic               proto_error
);

  // SIO must be sampled at least ~8x oversampled; a 700 kHz host needs clk >= ~6 MHz.
  if (sync_stages < 2 || sync_stages > 3 || clk_mhz < 6) begin : g_param_check
    $error("tm1638_responder: sync_stages must be 2..3 and clk_mhz at least 6");
  end

  logic sclk_level, sclk_rise, sclk_fall;
  logic stb_level, stb_rise, stb_fall;
  logic data_level, data_rise_unused, data_fall_unused;

  tm1638_sio_sync_edge #(.stages(sync_stages)) u_sync_clk (
    .clk    (clk),
    .din    (sio_clk),
    .level  (sclk_level),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  tm1638_sio_sync_edge #(.stages(sync_stages)) u_sync_stb (
    .clk    (clk),
    .din    (sio_stb),
    .level  (stb_level),
    .rise_c (stb_rise),
    .fall_c (stb_fall)
  );

  tm1638_sio_sync_edge #(.stages(sync_stages)) u_sync_data (
    .clk    (clk),
    .din    (sio_data_in),
    .level  (data_level),
    .rise_c (data_rise_unused),
    .fall_c (data_fall_unused)
  );

  state_t                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   mode_read_q, mode_read_d;
  logic                   mode_fixed_q, mode_fixed_d;
  logic [KEY_W-1:0]       snap_q, snap_d;
  logic [RD_CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                   got_byte_q, got_byte_d;
  logic                   wr_pending_q, wr_pending_d;
  logic [BYTE_W-1:0]      wr_byte_q, wr_byte_d;
  logic                   data_out_d, data_out_en_d;
  logic                   display_on_d;
  logic [2:0]             brightness_d;
  logic                   frame_done_d, proto_error_d;

  logic                   active;
  logic                   bit_in;
  logic                   byte_done;
  logic [BYTE_W-1:0]      rx_byte;
  cmd_kind_t              kind;

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      addr_q          <= '0;
      mode_read_q     <= 1'b0;
      mode_fixed_q    <= 1'b0;
      snap_q          <= '0;
      rd_cnt_q        <= '0;
      got_byte_q      <= 1'b0;
      wr_pending_q    <= 1'b0;
      wr_byte_q       <= '0;
      sio_data_out    <= 1'b0;
      sio_data_out_en <= 1'b0;
      display_on      <= 1'b0;
      brightness      <= '0;
      frame_done      <= 1'b0;
      proto_error     <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      addr_q          <= addr_d;
      mode_read_q     <= mode_read_d;
      mode_fixed_q    <= mode_fixed_d;
      snap_q          <= snap_d;
      rd_cnt_q        <= rd_cnt_d;
      got_byte_q      <= got_byte_d;
      wr_pending_q    <= wr_pending_d;
      wr_byte_q       <= wr_byte_d;
      sio_data_out    <= data_out_d;
      sio_data_out_en <= data_out_en_d;
      display_on      <= display_on_d;
      brightness      <= brightness_d;
      frame_done      <= frame_done_d;
      proto_error     <= proto_error_d;
    end
  end

  // Display RAM: a completed data byte lands one cycle after its 8th bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_ram <= '0;
    end else if (wr_pending_q) begin
      disp_ram[{addr_q, 3'b000} +: BYTE_W] <= wr_byte_q;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    addr_d        = addr_q;
    mode_read_d   = mode_read_q;
    mode_fixed_d  = mode_fixed_q;
    snap_d        = snap_q;
    rd_cnt_d      = rd_cnt_q;
    got_byte_d    = got_byte_q;
    wr_pending_d  = 1'b0;
    wr_byte_d     = wr_byte_q;
    data_out_d    = sio_data_out;
    data_out_en_d = sio_data_out_en;
    display_on_d  = display_on;
    brightness_d  = brightness;
    frame_done_d  = 1'b0;
    proto_error_d = 1'b0;

    // A strobe rising this cycle still frames any SIO edge seen in the same cycle.
    active    = ~stb_level | stb_rise;
    rx_byte   = {data_level, shift_q[BYTE_W-1:1]};
    bit_in    = active && sclk_rise && (state_q == S_CMD || state_q == S_WRITE);
    byte_done = bit_in && (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
    kind      = cmd_kind(rx_byte);

    if (wr_pending_q && !mode_fixed_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (bit_in) begin
      shift_d   = rx_byte;
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end

    if (byte_done) begin
      got_byte_d = 1'b1;
      if (state_q == S_CMD) begin
        case (kind)
          K_DATA: begin
            mode_read_d  = |(rx_byte & DATA_READ_MASK);
            mode_fixed_d = |(rx_byte & DATA_FIXED_MASK);
            if (mode_read_d) begin
              snap_d   = key_matrix;
              rd_cnt_d = '0;
              state_d  = S_READ;
            end else begin
              state_d  = S_DISCARD;
            end
          end
          K_ADDR: begin
            addr_d  = ADDR_W'(rx_byte & ADDR_MASK);
            state_d = S_WRITE;
          end
          K_DISP: begin
            display_on_d = |(rx_byte & DISP_ON_MASK);
            brightness_d = 3'(rx_byte & DISP_BRIGHT_MASK);
            state_d      = S_DISCARD;
          end
          default: begin
            proto_error_d = 1'b1;
            state_d       = S_DISCARD;
          end
        endcase
      end else begin
        wr_pending_d = 1'b1;
        wr_byte_d    = rx_byte;
      end
    end

    // Read data changes on SIO falls so it is stable at the host's next rise.
    if (state_q == S_READ && active && sclk_fall) begin
      data_out_en_d = 1'b1;
      if (rd_cnt_q < RD_CNT_W'(KEY_W)) begin
        data_out_d = snap_q[rd_cnt_q[4:0]];
        rd_cnt_d   = rd_cnt_q + RD_CNT_W'(1);
      end else begin
        data_out_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (stb_fall) begin
          state_d    = S_CMD;
          bit_cnt_d  = '0;
          got_byte_d = 1'b0;
        end
      end
      default: begin
        if (stb_rise) begin
          state_d       = S_IDLE;
          bit_cnt_d     = '0;
          got_byte_d    = 1'b0;
          data_out_d    = 1'b0;
          data_out_en_d = 1'b0;
          frame_done_d  = got_byte_q | byte_done;
          if (bit_in ? !byte_done : (bit_cnt_q != '0)) begin
            proto_error_d = 1'b1;
          end
        end
      end
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{sclk_level, data_rise_unused, data_fall_unused};

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: a host model drives SIO frames and a
// scoreboard monitor checks each frame_done snapshot and each clocked byte.
module tb_tm1638_responder;
  import tm1638_pkg::*;

  localparam int unsigned HALF = 8;

  typedef struct packed {
    logic [RAM_W-1:0] ram;
    logic             disp_on;
    logic [2:0]       bright;
    logic             perr;
  } frame_exp_t;

  typedef struct packed {
    logic              chk_data;
    logic [BYTE_W-1:0] data;
    logic              en;
  } byte_exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               sio_clk;
  logic               sio_stb;
  logic               sio_data_in;
  logic               sio_data_out;
  logic               sio_data_out_en;
  logic [KEY_W-1:0]   key_matrix;
  logic [RAM_W-1:0]   disp_ram;
  logic               display_on;
  logic [2:0]         brightness;
  logic               frame_done;
  logic               proto_error;

  frame_exp_t         fq[$];
  byte_exp_t          bq[$];
  frame_exp_t         fe;
  byte_exp_t          be;
  int                 checks;
  int                 errors;
  int                 frames_pushed;
  int                 frames_seen;
  logic [BYTE_W-1:0]  exp_ram [RAM_DEPTH];
  logic               exp_on;
  logic [2:0]         exp_bright;

  logic               prev_sclk, prev_stb, perr_seen, en_any, en_all;
  logic [BYTE_W-1:0]  sh;
  int                 nb;

  tm1638_responder #(.clk_mhz(50), .sync_stages(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .sio_clk         (sio_clk),
    .sio_stb         (sio_stb),
    .sio_data_in     (sio_data_in),
    .sio_data_out    (sio_data_out),
    .sio_data_out_en (sio_data_out_en),
    .key_matrix      (key_matrix),
    .disp_ram        (disp_ram),
    .display_on      (display_on),
    .brightness      (brightness),
    .frame_done      (frame_done),
    .proto_error     (proto_error)
  );

  always #10 clk = ~clk;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [RAM_W-1:0] ram_image();
    logic [RAM_W-1:0] img;
    for (int a = 0; a < RAM_DEPTH; a++) img[a*8 +: 8] = exp_ram[a];
    return img;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic sio_bit(input logic b);
    sio_clk = 1'b0;
    sio_data_in = b;
    tick(HALF);
    sio_clk = 1'b1;
    tick(HALF);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    bq.push_back('{chk_data: 1'b0, data: b, en: 1'b0});
    for (int i = 0; i < 8; i++) sio_bit(b[i]);
  endtask

  task automatic rx_byte(input logic [7:0] exp);
    bq.push_back('{chk_data: 1'b1, data: exp, en: 1'b1});
    for (int i = 0; i < 8; i++) sio_bit(1'b0);
  endtask

  task automatic frame_open();
    sio_stb = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_close(input logic perr, input logic expect_frame);
    tick(HALF);
    if (expect_frame) begin
      fq.push_back('{ram: ram_image(), disp_on: exp_on, bright: exp_bright, perr: perr});
      frames_pushed++;
    end
    sio_stb = 1'b1;
    for (int i = 0; i < 64 && frames_seen != frames_pushed; i++) tick(1);
    tick(HALF);
    check("frame_done_count", 128'(frames_seen), 128'(frames_pushed));
  endtask

  // Scoreboard monitor: pops a frame on each frame_done and a byte every 8 SIO rises.
  initial begin : monitor
    prev_sclk = 1'b1;
    prev_stb  = 1'b1;
    perr_seen = 1'b0;
    en_any    = 1'b0;
    en_all    = 1'b1;
    sh        = '0;
    nb        = 0;
    forever begin
      @(negedge clk);
      if (proto_error) perr_seen = 1'b1;
      if (frame_done) begin
        if (fq.size() == 0) begin
          check("unexpected_frame_done", 128'(1), 128'(0));
        end else begin
          fe = fq.pop_front();
          check("frame_ram", 128'(disp_ram), 128'(fe.ram));
          check("frame_display_on", 128'(display_on), 128'(fe.disp_on));
          check("frame_brightness", 128'(brightness), 128'(fe.bright));
          check("frame_proto_error", 128'(perr_seen), 128'(fe.perr));
        end
        frames_seen++;
        perr_seen = 1'b0;
      end
      if (sio_stb && !prev_stb) begin
        nb = 0;
      end else if (!sio_stb && sio_clk && !prev_sclk) begin
        if (nb == 0) begin
          en_any = 1'b0;
          en_all = 1'b1;
        end
        sh     = {sio_data_out, sh[7:1]};
        en_any = en_any | sio_data_out_en;
        en_all = en_all & sio_data_out_en;
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (bq.size() == 0) begin
            check("unexpected_byte", 128'(1), 128'(0));
          end else begin
            be = bq.pop_front();
            check("byte_out_en", 128'({en_any, en_all}), be.en ? 128'(3) : 128'(0));
            if (be.chk_data) check("read_byte", 128'(sh), 128'(be.data));
          end
        end
      end
      prev_sclk = sio_clk;
      prev_stb  = sio_stb;
    end
  end

  initial begin : stimulus
    checks = 0;
    errors = 0;
    frames_pushed = 0;
    frames_seen = 0;
    for (int a = 0; a < RAM_DEPTH; a++) exp_ram[a] = 8'h00;
    exp_on = 1'b0;
    exp_bright = 3'd0;
    rst = 1'b1;
    sio_clk = 1'b1;
    sio_stb = 1'b1;
    sio_data_in = 1'b0;
    key_matrix = '0;
    tick(10);
    rst = 1'b0;
    tick(2);
    check("rst_disp_ram", 128'(disp_ram), 128'(0));
    check("rst_display_on", 128'(display_on), 128'(0));
    check("rst_brightness", 128'(brightness), 128'(0));
    check("rst_data_out", 128'(sio_data_out), 128'(0));
    check("rst_data_out_en", 128'(sio_data_out_en), 128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
    check("rst_proto_error", 128'(proto_error), 128'(0));

    // Write command alone, then address 0 with 16 auto-incremented bytes.
    frame_open(); tx_byte(C_WRITE_DISP); frame_close(1'b0, 1'b1);
    frame_open(); tx_byte(C_SET_ADDR_0);
    for (int a = 0; a < RAM_DEPTH; a++) begin
      tx_byte(8'(a));
      exp_ram[a] = 8'(a);
    end
    frame_close(1'b0, 1'b1);

    // Fixed address: both data bytes hit address 5.
    frame_open(); tx_byte(8'h44); frame_close(1'b0, 1'b1);
    frame_open(); tx_byte(8'hC5); tx_byte(8'hAB); tx_byte(8'hCD);
    exp_ram[5] = 8'hCD;
    frame_close(1'b0, 1'b1);

    // Auto-increment wraps 15 -> 0.
    frame_open(); tx_byte(C_WRITE_DISP); frame_close(1'b0, 1'b1);
    frame_open(); tx_byte(8'hCF); tx_byte(8'h11); tx_byte(8'h22);
    exp_ram[15] = 8'h11;
    exp_ram[0]  = 8'h22;
    frame_close(1'b0, 1'b1);

    // Display control on/full brightness, then off/zero.
    frame_open(); tx_byte(C_DISPLAY_ON);
    exp_on = 1'b1; exp_bright = 3'd7;
    frame_close(1'b0, 1'b1);
    frame_open(); tx_byte(8'h80);
    exp_on = 1'b0; exp_bright = 3'd0;
    frame_close(1'b0, 1'b1);

    // Key read: four snapshot bytes then zeros.
    key_matrix = 32'h8040_2011;
    frame_open(); tx_byte(C_READ_KEYS);
    rx_byte(8'h11); rx_byte(8'h20); rx_byte(8'h40); rx_byte(8'h80); rx_byte(8'h00);
    frame_close(1'b0, 1'b1);
    check("out_en_after_stb", 128'(sio_data_out_en), 128'(0));

    // Partial data byte is dropped with a protocol error; next write succeeds.
    frame_open(); tx_byte(8'hC3); sio_bit(1'b1); sio_bit(1'b0); sio_bit(1'b1);
    frame_close(1'b1, 1'b1);
    frame_open(); tx_byte(8'hC3); tx_byte(8'h5A);
    exp_ram[3] = 8'h5A;
    frame_close(1'b0, 1'b1);

    // Unrecognised command class.
    frame_open(); tx_byte(8'h00); frame_close(1'b1, 1'b1);

    // Reset mid-frame: everything clears and the rest of the frame is ignored.
    frame_open(); tx_byte(8'hC0);
    for (int i = 0; i < 4; i++) sio_bit(1'b1);
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    sio_bit(1'b0); sio_bit(1'b1);
    for (int a = 0; a < RAM_DEPTH; a++) exp_ram[a] = 8'h00;
    exp_on = 1'b0; exp_bright = 3'd0;
    frame_close(1'b0, 1'b0);
    check("midrst_disp_ram", 128'(disp_ram), 128'(0));
    check("midrst_out_en", 128'(sio_data_out_en), 128'(0));

    frame_open(); tx_byte(8'hC2); tx_byte(8'h77);
    exp_ram[2] = 8'h77;
    frame_close(1'b0, 1'b1);

    tick(20);
    check("frames_left", 128'(fq.size()), 128'(0));
    check("bytes_left", 128'(bq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
